// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// -------------------------------------------------------------------------
// Register-file hazard controller for the pipelined Y86-64 core.
// It keeps one pending-write counter for each of the 15 program registers.
// Decode is stalled while any of these conditions holds:
//   - a source register still has a write in flight;
//   - a destination counter is already saturated.
// As a result, the combinational register-file read ports only ever see
// committed values.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   issue_valid             decode presents an instruction
//   issue_srcA/B            source register IDs (RNONE = unused)
//   issue_dstE/M            destination register IDs (RNONE = unused)
//   issue_ready, stall      accept / combinational stall (ready = ~stall)
//   wb_valid, wb_dstE/M     writeback retires up to two destinations
//   flush                   synchronous clear of all counters
//   busy[14:0]              bit r set while counter[r] != 0
//   inflight                total pending register writes
//   underflow_err           sticky; a retire hit an idle register
// -------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int         CNT_W = 2,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [3:0]       issue_srcA,
  input  logic [3:0]       issue_srcB,
  input  logic [3:0]       issue_dstE,
  input  logic [3:0]       issue_dstM,
  output logic             issue_ready,
  output logic             stall,
  input  logic             wb_valid,
  input  logic [3:0]       wb_dstE,
  input  logic [3:0]       wb_dstM,
  input  logic             flush,
  output logic [14:0]      busy,
  output logic [CNT_W+1:0] inflight,
  output logic             underflow_err
);

  localparam int               NREG    = 15;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // State
  logic [CNT_W-1:0] counter_q [NREG];
  logic [CNT_W-1:0] counter_d [NREG];
  logic [CNT_W+1:0] inflight_q, inflight_d;
  logic             underflow_q, underflow_d;

  // Per-register decode of the issue / retire / source IDs
  logic [NREG-1:0] nz;       // counter != 0
  logic [NREG-1:0] at_max;   // counter saturated
  logic [NREG-1:0] sel_a;    // srcA names this register
  logic [NREG-1:0] sel_b;    // srcB names this register
  logic [NREG-1:0] in_di;    // register is in the issue destination set
  logic [NREG-1:0] in_dw;    // register is in the retire destination set
  logic [NREG-1:0] inc;      // accepted issue writes this register
  logic [NREG-1:0] dec;      // legal retire of this register
  logic [NREG-1:0] uf;       // retire of a register with nothing pending

  logic accept;
  logic src_hazard;
  logic dst_full;

  // Set membership is evaluated as "ID equals r", so a repeated ID
  // (dstE == dstM) selects the same bit and counts once.
  // RNONE is masked so that a design with RNONE inside 0..14 also behaves.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [3:0] RID = 4'(gi);
      localparam logic       REAL = (RID != RNONE);

      assign nz[gi]     = (counter_q[gi] != '0);
      assign at_max[gi] = (counter_q[gi] == CNT_MAX);
      assign sel_a[gi]  = REAL && (issue_srcA == RID);
      assign sel_b[gi]  = REAL && (issue_srcB == RID);
      assign in_di[gi]  = REAL && ((issue_dstE == RID) || (issue_dstM == RID));
      assign in_dw[gi]  = REAL && ((wb_dstE == RID) || (wb_dstM == RID));
      assign inc[gi]    = accept && in_di[gi];
      assign dec[gi]    = wb_valid && in_dw[gi] && nz[gi];
      assign uf[gi]     = wb_valid && in_dw[gi] && !nz[gi];
    end
  endgenerate

  // Stall only looks at the registered counters. A same-cycle retire is not
  // bypassed, because the register file only takes the new value at the edge.
  assign src_hazard  = |((sel_a | sel_b) & nz);
  assign dst_full    = |(in_di & at_max);
  assign stall       = issue_valid && (src_hazard || dst_full);
  assign issue_ready = !stall;
  assign accept      = issue_valid && !stall;

  // Next-state: counters and the in-flight total
  always_comb begin
    logic [CNT_W+1:0] n_inc;
    logic [CNT_W+1:0] n_dec;
    n_inc = '0;
    n_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      counter_d[i] = counter_q[i];
      n_inc        = n_inc + {{(CNT_W+1){1'b0}}, inc[i]};
      n_dec        = n_dec + {{(CNT_W+1){1'b0}}, dec[i]};
      if (flush) begin
        counter_d[i] = '0;
      end else if (inc[i] && !dec[i]) begin
        counter_d[i] = counter_q[i] + CNT_ONE;
      end else if (dec[i] && !inc[i]) begin
        counter_d[i] = counter_q[i] - CNT_ONE;
      end
    end
    if (flush) begin
      inflight_d = '0;
    end else begin
      inflight_d = inflight_q + n_inc - n_dec;
    end
  end

  // The error is a diagnostic of the writeback stream. It is still recorded
  // in a flush cycle: the counters are discarded, but the bad retire happened.
  assign underflow_d = underflow_q || (|uf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        counter_q[i] <= '0;
      end
      inflight_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        counter_q[i] <= counter_d[i];
      end
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  assign busy          = nz;
  assign inflight      = inflight_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard.
// A per-register count model is compared against the DUT on every falling
// edge. Directed steps with literal expectations pin that model.
module tb_regfile_scoreboard;

  localparam int         CNT_W = 2;
  localparam int         MAXC  = 3;
  localparam logic [3:0] NR    = 4'hF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             issue_valid = 1'b0;
  logic [3:0]       issue_srcA = NR, issue_srcB = NR, issue_dstE = NR, issue_dstM = NR;
  logic             issue_ready, stall;
  logic             wb_valid = 1'b0;
  logic [3:0]       wb_dstE = NR, wb_dstM = NR;
  logic             flush = 1'b0;
  logic [14:0]      busy;
  logic [CNT_W+1:0] inflight;
  logic             underflow_err;

  regfile_scoreboard #(.CNT_W(CNT_W), .RNONE(4'hF)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_srcA(issue_srcA), .issue_srcB(issue_srcB),
    .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
    .issue_ready(issue_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
    .flush(flush), .busy(busy), .inflight(inflight), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model state: plain integer pending counts per register
  int cnt [15];
  int infl = 0;
  bit uf_m = 1'b0;

  initial begin
    for (int i = 0; i < 15; i++) cnt[i] = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    if (issue_srcA != NR && cnt[issue_srcA] != 0) return 1'b1;
    if (issue_srcB != NR && cnt[issue_srcB] != 0) return 1'b1;
    if (issue_dstE != NR && cnt[issue_dstE] == MAXC) return 1'b1;
    if (issue_dstM != NR && cnt[issue_dstM] == MAXC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [14:0] m_busy();
    logic [14:0] b;
    b = '0;
    for (int i = 0; i < 15; i++) b[i] = (cnt[i] != 0);
    return b;
  endfunction

  // Model update at each edge (inputs are held stable across the edge)
  always @(posedge clk or posedge reset) begin : model
    int old [15];
    bit acc;
    if (reset) begin
      for (int i = 0; i < 15; i++) cnt[i] = 0;
      infl = 0;
      uf_m = 1'b0;
    end else begin
      old = cnt;
      acc = issue_valid && !m_stall();
      if (wb_valid) begin
        if (wb_dstE != NR && old[wb_dstE] == 0) uf_m = 1'b1;
        if (wb_dstM != NR && old[wb_dstM] == 0) uf_m = 1'b1;
      end
      if (flush) begin
        for (int i = 0; i < 15; i++) cnt[i] = 0;
        infl = 0;
      end else begin
        if (acc) begin
          if (issue_dstE != NR) begin cnt[issue_dstE]++; infl++; end
          if (issue_dstM != NR && issue_dstM != issue_dstE) begin cnt[issue_dstM]++; infl++; end
        end
        if (wb_valid) begin
          if (wb_dstE != NR && old[wb_dstE] != 0) begin cnt[wb_dstE]--; infl--; end
          if (wb_dstM != NR && wb_dstM != wb_dstE && old[wb_dstM] != 0) begin cnt[wb_dstM]--; infl--; end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_stall", {31'd0, stall}, {31'd0, m_stall()});
      check("cyc_ready", {31'd0, issue_ready}, {31'd0, !m_stall()});
      check("cyc_busy", {17'd0, busy}, {17'd0, m_busy()});
      check("cyc_inflight", {28'd0, inflight}, 32'(infl & 15));
      check("cyc_underflow", {31'd0, underflow_err}, {31'd0, uf_m});
    end
  end

  task automatic drive(input bit v, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] de, input logic [3:0] dm,
                       input bit wv, input logic [3:0] we, input logic [3:0] wm,
                       input bit fl);
    issue_valid = v; issue_srcA = sa; issue_srcB = sb;
    issue_dstE = de; issue_dstM = dm;
    wb_valid = wv; wb_dstE = we; wb_dstM = wm; flush = fl;
  endtask

  task automatic idle();
    drive(0, NR, NR, NR, NR, 0, NR, NR, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_on = 1'b1;
    check("rst_busy", {17'd0, busy}, 32'h0);
    check("rst_inflight", {28'd0, inflight}, 32'h0);
    check("rst_underflow", {31'd0, underflow_err}, 32'h0);

    // Single issue of r3
    drive(1, NR, NR, 4'd3, NR, 0, NR, NR, 0);
    #1 check("issue3_ready", {31'd0, issue_ready}, 32'h1);
    tick(); idle();
    check("issue3_busy", {17'd0, busy}, 32'h0008);
    check("issue3_inflight", {28'd0, inflight}, 32'h1);

    // Read of r3 stalls until its retire edge has passed
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'd3, NR, NR, NR, 0, NR, NR, 0);
      #1 check("raw3_stall", {31'd0, stall}, 32'h1);
      tick();
    end
    drive(1, 4'd3, NR, NR, NR, 1, 4'd3, NR, 0);
    #1 check("raw3_retire_stall", {31'd0, stall}, 32'h1);
    tick();
    drive(1, 4'd3, NR, NR, NR, 0, NR, NR, 0);
    #1 check("raw3_free_stall", {31'd0, stall}, 32'h0);
    check("raw3_free_busy", {17'd0, busy}, 32'h0);
    tick(); idle();

    // Saturation of r5
    for (int k = 0; k < 3; k++) begin
      drive(1, NR, NR, 4'd5, NR, 0, NR, NR, 0);
      #1 check("sat5_ready", {31'd0, issue_ready}, 32'h1);
      tick();
    end
    drive(1, NR, NR, 4'd5, NR, 1, 4'd5, NR, 0);
    #1 check("sat5_full_stall", {31'd0, stall}, 32'h1);
    tick();
    check("sat5_after_retire", {28'd0, inflight}, 32'h2);
    drive(1, NR, NR, 4'd5, NR, 0, NR, NR, 0);
    #1 check("sat5_accept", {31'd0, stall}, 32'h0);
    tick(); idle();
    check("sat5_inflight", {28'd0, inflight}, 32'h3);
    for (int k = 0; k < 3; k++) begin
      drive(0, NR, NR, NR, NR, 1, 4'd5, NR, 0);
      tick();
    end
    idle();
    check("sat5_drained", {28'd0, inflight}, 32'h0);

    // Simultaneous issue and retire of r2
    drive(1, NR, NR, 4'd2, NR, 0, NR, NR, 0); tick();
    drive(1, NR, NR, 4'd2, NR, 1, 4'd2, NR, 0); tick(); idle();
    check("simul2_inflight", {28'd0, inflight}, 32'h1);
    check("simul2_busy", {17'd0, busy}, 32'h0004);
    drive(0, NR, NR, NR, NR, 1, 4'd2, NR, 0); tick(); idle();

    // Duplicate destinations, then underflow
    drive(1, NR, NR, 4'd4, 4'd4, 0, NR, NR, 0); tick(); idle();
    check("dup4_busy", {17'd0, busy}, 32'h0010);
    check("dup4_inflight", {28'd0, inflight}, 32'h1);
    drive(0, NR, NR, NR, NR, 1, 4'd4, 4'd4, 0); tick(); idle();
    check("dup4_ret_busy", {17'd0, busy}, 32'h0);
    check("dup4_ret_uf", {31'd0, underflow_err}, 32'h0);
    drive(0, NR, NR, NR, NR, 1, 4'd4, NR, 0); tick(); idle();
    check("uf_set", {31'd0, underflow_err}, 32'h1);
    drive(0, NR, NR, NR, NR, 0, NR, NR, 1); tick(); idle();
    check("uf_after_flush", {31'd0, underflow_err}, 32'h1);
    reset = 1'b1;
    #1 check("uf_reset", {31'd0, underflow_err}, 32'h0);
    reset = 1'b0;
    tick();

    // Flush together with an issue
    drive(1, NR, NR, 4'd1, NR, 0, NR, NR, 0); tick();
    drive(1, NR, NR, 4'd1, NR, 0, NR, NR, 0); tick();
    drive(1, NR, NR, 4'd7, NR, 0, NR, NR, 0); tick(); idle();
    check("pre_flush_busy", {17'd0, busy}, 32'h0082);
    check("pre_flush_inflight", {28'd0, inflight}, 32'h3);
    drive(1, NR, NR, 4'd9, NR, 0, NR, NR, 1);
    #1 check("flush_ready", {31'd0, issue_ready}, 32'h1);
    tick(); idle();
    check("flush_busy", {17'd0, busy}, 32'h0);
    check("flush_inflight", {28'd0, inflight}, 32'h0);

    // srcB hazard
    drive(1, NR, NR, 4'd6, NR, 0, NR, NR, 0); tick();
    drive(1, NR, 4'd6, NR, NR, 0, NR, NR, 0);
    #1 check("srcB6_stall", {31'd0, stall}, 32'h1);
    tick(); idle();

    // Asynchronous reset in the middle of a cycle
    drive(1, NR, NR, 4'd1, NR, 0, NR, NR, 0); tick(); idle();
    check("pre_areset_busy", {17'd0, busy}, 32'h0042);
    #2 reset = 1'b1;
    #1;
    check("areset_busy", {17'd0, busy}, 32'h0);
    check("areset_inflight", {28'd0, inflight}, 32'h0);
    check("areset_underflow", {31'd0, underflow_err}, 32'h0);
    check("areset_stall", {31'd0, stall}, 32'h0);
    reset = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
